// File: rtl/pipe_stall_ctrl.sv
// Pipeline sequencer: merges stage stall requests, runs the MEM-stage bus handshake,
// defers flushes past in-flight accesses and counts stalled cycles.
module pipe_stall_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 16,
   parameter int unsigned CNT_W          = 5,
   parameter int unsigned PERF_W         = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stallreq_id,
   input  logic              stallreq_ex,
   input  logic              mem_access_i,
   input  logic              flush_i,
   input  logic              bus_ack_i,
   output logic [5:0]        stall_o,
   output logic              flush_o,
   output logic              bus_req_o,
   output logic              timeout_o,
   output logic [PERF_W-1:0] stall_cycles_o
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_WAIT_ACK = 2'd1,
      S_DONE     = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [CNT_W-1:0]    r_tcnt;
   logic [CNT_W-1:0]    w_tcnt_nxt;
   logic                r_flush_pend;
   logic                w_flush_pend_nxt;
   logic                r_bus_req;
   logic                w_bus_req_nxt;
   logic                r_timeout;
   logic                w_timeout_nxt;
   logic [PERF_W-1:0]   r_stall_cycles;
   logic                w_stallreq_mem;
   logic                w_flush;
   logic [5:0]          w_stall;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_tcnt       <= '0;
         r_flush_pend <= 1'b0;
         r_bus_req    <= 1'b0;
         r_timeout    <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_tcnt       <= w_tcnt_nxt;
         r_flush_pend <= w_flush_pend_nxt;
         r_bus_req    <= w_bus_req_nxt;
         r_timeout    <= w_timeout_nxt;
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_tcnt_nxt       = r_tcnt;
      w_flush_pend_nxt = r_flush_pend;
      w_bus_req_nxt    = r_bus_req;
      w_timeout_nxt    = r_timeout;
      case (r_state)
         S_IDLE: begin
            if (mem_access_i && !flush_i) begin
               w_state_nxt   = S_WAIT_ACK;
               w_tcnt_nxt    = '0;
               w_bus_req_nxt = 1'b1;
            end
         end
         S_WAIT_ACK: begin
            // A flush here must not abort the access; it is replayed in DONE.
            if (flush_i)
               w_flush_pend_nxt = 1'b1;
            if (bus_ack_i) begin
               w_state_nxt   = S_DONE;
               w_bus_req_nxt = 1'b0;
            end else if (r_tcnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               w_state_nxt   = S_DONE;
               w_bus_req_nxt = 1'b0;
               w_timeout_nxt = 1'b1;
            end else begin
               w_tcnt_nxt = r_tcnt + CNT_W'(1);
            end
         end
         S_DONE: begin
            w_state_nxt      = S_IDLE;
            w_flush_pend_nxt = 1'b0;
            w_timeout_nxt    = 1'b0;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_comb begin
      w_stallreq_mem = ((r_state == S_IDLE) && mem_access_i && !flush_i) ||
                       (r_state == S_WAIT_ACK);
      w_flush        = !rst && ((flush_i && (r_state != S_WAIT_ACK)) ||
                                ((r_state == S_DONE) && r_flush_pend));
      w_stall        = 6'b000000;
      if (rst || w_flush)
         w_stall = 6'b000000;
      else if (w_stallreq_mem)
         w_stall = 6'b011111;
      else if (stallreq_ex)
         w_stall = 6'b001111;
      else if (stallreq_id)
         w_stall = 6'b000111;
   end

   always_ff @(posedge clk) begin
      if (rst)
         r_stall_cycles <= '0;
      else if ((w_stall != 6'b000000) && (r_stall_cycles != '1))
         r_stall_cycles <= r_stall_cycles + PERF_W'(1);
   end

   assign stall_o        = w_stall;
   assign flush_o        = w_flush;
   assign bus_req_o      = r_bus_req;
   assign timeout_o      = r_timeout;
   assign stall_cycles_o = r_stall_cycles;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl; a second instance with a 4-bit perf counter
// exercises counter saturation.
module tb_pipe_stall_ctrl;

   logic        clk;
   logic        rst;
   logic        stallreq_id;
   logic        stallreq_ex;
   logic        mem_access_i;
   logic        flush_i;
   logic        bus_ack_i;
   logic [5:0]  stall_o;
   logic        flush_o;
   logic        bus_req_o;
   logic        timeout_o;
   logic [31:0] stall_cycles_o;
   logic [5:0]  s_stall_o;
   logic        s_flush_o;
   logic        s_bus_req_o;
   logic        s_timeout_o;
   logic [3:0]  s_stall_cycles_o;

   int unsigned n_pass  = 0;
   int unsigned n_total = 0;

   pipe_stall_ctrl #(.TIMEOUT_CYCLES(16), .CNT_W(5), .PERF_W(32)) dut (
      .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex),
      .mem_access_i(mem_access_i), .flush_i(flush_i), .bus_ack_i(bus_ack_i),
      .stall_o(stall_o), .flush_o(flush_o), .bus_req_o(bus_req_o),
      .timeout_o(timeout_o), .stall_cycles_o(stall_cycles_o)
   );

   pipe_stall_ctrl #(.TIMEOUT_CYCLES(16), .CNT_W(5), .PERF_W(4)) dut_sat (
      .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex),
      .mem_access_i(mem_access_i), .flush_i(flush_i), .bus_ack_i(bus_ack_i),
      .stall_o(s_stall_o), .flush_o(s_flush_o), .bus_req_o(s_bus_req_o),
      .timeout_o(s_timeout_o), .stall_cycles_o(s_stall_cycles_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      else
         n_pass++;
   endtask

   // Inputs change 1 time unit after the edge; outputs are sampled 1 unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; stallreq_id = 1'b0; stallreq_ex = 1'b0;
      mem_access_i = 1'b0; flush_i = 1'b0; bus_ack_i = 1'b0;
      #1;

      // 1. reset with toggling inputs
      mem_access_i = 1'b1; flush_i = 1'b1; stallreq_ex = 1'b1; stallreq_id = 1'b1; bus_ack_i = 1'b1;
      settle();
      chk("rst_stall_a", 32'(stall_o), 32'h00);
      chk("rst_flush_a", 32'(flush_o), 32'h0);
      tick();
      flush_i = 1'b0; bus_ack_i = 1'b0; stallreq_id = 1'b0;
      settle();
      chk("rst_stall_b", 32'(stall_o), 32'h00);
      chk("rst_flush_b", 32'(flush_o), 32'h0);
      chk("rst_busreq", 32'(bus_req_o), 32'h0);
      chk("rst_timeout", 32'(timeout_o), 32'h0);
      chk("rst_cnt", stall_cycles_o, 32'd0);
      tick();
      rst = 1'b0; mem_access_i = 1'b0; stallreq_ex = 1'b0;
      settle();
      chk("post_rst_stall", 32'(stall_o), 32'h00);
      chk("post_rst_busreq", 32'(bus_req_o), 32'h0);
      chk("post_rst_cnt", stall_cycles_o, 32'd0);

      // 2. load acked 3 cycles after bus_req rises
      mem_access_i = 1'b1;
      settle();
      chk("ld_t0_stall", 32'(stall_o), 32'h1f);
      chk("ld_t0_busreq", 32'(bus_req_o), 32'h0);
      tick();
      for (int i = 1; i <= 3; i++) begin
         if (i == 3) bus_ack_i = 1'b1;
         settle();
         chk("ld_wait_stall", 32'(stall_o), 32'h1f);
         chk("ld_wait_busreq", 32'(bus_req_o), 32'h1);
         tick();
      end
      bus_ack_i = 1'b0; mem_access_i = 1'b0;
      settle();
      chk("ld_done_stall", 32'(stall_o), 32'h00);
      chk("ld_done_busreq", 32'(bus_req_o), 32'h0);
      chk("ld_done_timeout", 32'(timeout_o), 32'h0);
      chk("ld_done_flush", 32'(flush_o), 32'h0);
      chk("ld_cnt", stall_cycles_o, 32'd4);
      chk("ld_cnt_small", 32'(s_stall_cycles_o), 32'd4);
      tick();
      settle();
      chk("ld_idle_cnt", stall_cycles_o, 32'd4);

      // 3. timeout: ack never arrives
      mem_access_i = 1'b1;
      tick();
      for (int i = 0; i < 16; i++) begin
         settle();
         chk("to_busreq", 32'(bus_req_o), 32'h1);
         chk("to_pulse_early", 32'(timeout_o), 32'h0);
         tick();
      end
      mem_access_i = 1'b0;
      settle();
      chk("to_done_busreq", 32'(bus_req_o), 32'h0);
      chk("to_done_pulse", 32'(timeout_o), 32'h1);
      chk("to_done_stall", 32'(stall_o), 32'h00);
      chk("to_cnt", stall_cycles_o, 32'd21);
      tick();
      settle();
      chk("to_idle_pulse", 32'(timeout_o), 32'h0);
      chk("to_idle_busreq", 32'(bus_req_o), 32'h0);

      // 4. flush during WAIT_ACK deferred to DONE
      mem_access_i = 1'b1;
      tick();
      settle();
      chk("fl_w1_flush", 32'(flush_o), 32'h0);
      tick();
      flush_i = 1'b1;
      settle();
      chk("fl_w2_flush", 32'(flush_o), 32'h0);
      chk("fl_w2_stall", 32'(stall_o), 32'h1f);
      tick();
      flush_i = 1'b0;
      settle();
      chk("fl_w3_flush", 32'(flush_o), 32'h0);
      tick();
      bus_ack_i = 1'b1;
      settle();
      chk("fl_w4_flush", 32'(flush_o), 32'h0);
      chk("fl_w4_busreq", 32'(bus_req_o), 32'h1);
      tick();
      bus_ack_i = 1'b0; mem_access_i = 1'b0;
      settle();
      chk("fl_done_flush", 32'(flush_o), 32'h1);
      chk("fl_done_stall", 32'(stall_o), 32'h00);
      chk("fl_cnt", stall_cycles_o, 32'd26);
      tick();
      settle();
      chk("fl_idle_flush", 32'(flush_o), 32'h0);

      // 5. priority of stall sources
      stallreq_ex = 1'b1; stallreq_id = 1'b1;
      settle();
      chk("pri_ex", 32'(stall_o), 32'h0f);
      tick();
      stallreq_ex = 1'b0;
      settle();
      chk("pri_id", 32'(stall_o), 32'h07);
      tick();
      mem_access_i = 1'b1;
      settle();
      chk("pri_mem", 32'(stall_o), 32'h1f);
      flush_i = 1'b1;
      settle();
      chk("pri_flush_stall", 32'(stall_o), 32'h00);
      chk("pri_flush_o", 32'(flush_o), 32'h1);
      tick();
      mem_access_i = 1'b0; flush_i = 1'b0; stallreq_id = 1'b0;
      settle();
      chk("pri_no_access", 32'(bus_req_o), 32'h0);
      chk("pri_cnt", stall_cycles_o, 32'd28);

      // 6. reset in the middle of WAIT_ACK with a pending flush
      mem_access_i = 1'b1;
      tick();
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0; rst = 1'b1;
      settle();
      chk("mr_stall_gated", 32'(stall_o), 32'h00);
      chk("mr_flush_gated", 32'(flush_o), 32'h0);
      tick();
      rst = 1'b0; mem_access_i = 1'b0;
      settle();
      chk("mr_busreq", 32'(bus_req_o), 32'h0);
      chk("mr_cnt", stall_cycles_o, 32'd0);
      chk("mr_stall", 32'(stall_o), 32'h00);
      mem_access_i = 1'b1;
      tick();
      bus_ack_i = 1'b1;
      settle();
      chk("mr_restart_busreq", 32'(bus_req_o), 32'h1);
      tick();
      bus_ack_i = 1'b0; mem_access_i = 1'b0;
      settle();
      chk("mr_pend_cleared", 32'(flush_o), 32'h0);
      chk("mr_done_cnt", stall_cycles_o, 32'd2);
      tick();

      // saturation on the 4-bit counter
      stallreq_ex = 1'b1;
      for (int i = 0; i < 20; i++) tick();
      settle();
      chk("sat_small", 32'(s_stall_cycles_o), 32'd15);
      chk("sat_main", stall_cycles_o, 32'd22);
      tick();
      tick();
      settle();
      chk("sat_small_hold", 32'(s_stall_cycles_o), 32'd15);
      stallreq_ex = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
